bit_select_mux: RTL and testbench

//   Width-parameterised N:1 bit multiplexer: selects one bit of i_data by index i_sel.

---
 rtl/bit_select_mux_pkg.sv | 25 ++
 rtl/bit_select_mux_mux2_stage.sv | 21 ++
 rtl/bit_select_mux.sv | 119 +++++++++++
 tb/tb_bit_select_mux.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_select_mux_pkg.sv
// -----------------------------------------------------------------------------
// bit_select_mux_pkg
//   Shared constants and helpers for the bit-select multiplexer.
//   - DEFAULT_WIDTH / DEFAULT_SEL_WIDTH : default parameterisation of the mux.
//   - clog2()                           : depth of the 2:1 select tree.
// -----------------------------------------------------------------------------
package bit_select_mux_pkg;

   localparam int DEFAULT_WIDTH     = 32;
   localparam int DEFAULT_SEL_WIDTH = 5;

   // Number of 2:1 levels needed to reduce 'value' leaves to one bit.
   function automatic int clog2(input int value);
      int result;
      int span;
      result = 0;
      span   = 1;
      while (span < value) begin
         span   = span << 1;
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/bit_select_mux_mux2_stage.sv
// -----------------------------------------------------------------------------
// bit_select_mux_mux2_stage
//   Single 2:1 bit multiplexer, the node of the select tree in bit_select_mux.
// Ports:
//   i_a   in  1  candidate chosen when i_sel = 0
//   i_b   in  1  candidate chosen when i_sel = 1
//   i_sel in  1  select
//   o_y   out 1  selected bit
// -----------------------------------------------------------------------------
module bit_select_mux_mux2_stage
   import bit_select_mux_pkg::*;
(
   input  logic i_a,
   input  logic i_b,
   input  logic i_sel,
   output logic o_y
);

   assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/bit_select_mux.sv
// -----------------------------------------------------------------------------
// bit_select_mux
//   WIDTH:1 bit multiplexer with a registered output. Selects i_data[i_sel]
//   (0 when i_sel >= WIDTH) and captures it when i_en is high. One instance is
//   used per result bit of the barrel shifter.
//
// Parameters:
//   WIDTH      number of data bits (>= 2)
//   SEL_WIDTH  width of the select index (>= 1, independent of WIDTH)
//
// Ports:
//   i_clk    in  1          clock, rising edge
//   i_rst_n  in  1          asynchronous active-low reset
//   i_data   in  WIDTH      candidate bits, channel k = i_data[k]
//   i_sel    in  SEL_WIDTH  unsigned channel index
//   i_en     in  1          capture enable
//   o_out    out 1          registered selected bit
//   o_valid  out 1          high the cycle after a capture
//   o_oor    out 1          (BIT_MUX_OOR_FLAG_EN only) captured i_sel >= WIDTH
//
// Configuration macro:
//   BIT_MUX_OOR_FLAG_EN  adds the o_oor out-of-range flag output.
// -----------------------------------------------------------------------------
module bit_select_mux
   import bit_select_mux_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int SEL_WIDTH = DEFAULT_SEL_WIDTH
)(
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [WIDTH-1:0]     i_data,
   input  logic [SEL_WIDTH-1:0] i_sel,
   input  logic                 i_en,
   output logic                 o_out,
   output logic                 o_valid
`ifdef BIT_MUX_OOR_FLAG_EN
   ,
   output logic                 o_oor
`endif
);

   localparam int DEPTH = clog2(WIDTH);
   localparam int PAD   = 1 << DEPTH;
   // Wide enough to hold both every i_sel value and WIDTH itself, so the
   // range check never truncates or wraps the index.
   localparam int CMP_W = (SEL_WIDTH > DEPTH + 1) ? SEL_WIDTH : DEPTH + 1;

   logic [CMP_W-1:0] sel_ext_p0;
   logic             in_range_p0;
   logic             tree_bit_p0;
   logic             sel_bit_p0;
   logic             out_p1;
   logic             vld_p1;

   assign sel_ext_p0 = CMP_W'(i_sel);

   // Select tree: level 0 holds the data padded with zeros to a power of two,
   // each further level halves the candidates using one select bit, LSB first.
   for (genvar l = 0; l <= DEPTH; l++) begin : g_level
      logic [(PAD >> l)-1:0] lvl;
      if (l == 0) begin : g_leaf
         for (genvar k = 0; k < PAD; k++) begin : g_bit
            if (k < WIDTH) begin : g_data
               assign lvl[k] = i_data[k];
            end else begin : g_pad
               assign lvl[k] = 1'b0;
            end
         end
      end else begin : g_mux
         for (genvar j = 0; j < (PAD >> l); j++) begin : g_node
            bit_select_mux_mux2_stage u_mux2 (
               .i_a   (g_level[l-1].lvl[2*j]),
               .i_b   (g_level[l-1].lvl[2*j+1]),
               .i_sel (sel_ext_p0[l-1]),
               .o_y   (lvl[j])
            );
         end
      end
   end

   assign tree_bit_p0 = g_level[DEPTH].lvl[0];

   // The tree only looks at the low DEPTH select bits, so an out-of-range
   // index would alias onto a real channel; force 0 in that case.
   assign in_range_p0 = (sel_ext_p0 < CMP_W'(WIDTH));
   assign sel_bit_p0  = in_range_p0 ? tree_bit_p0 : 1'b0;

   // ---- stage p0 -> p1: output register ----
`ifdef BIT_MUX_OOR_FLAG_EN
   logic oor_p1;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         oor_p1 <= 1'b0;
      end else if (i_en) begin
         oor_p1 <= ~in_range_p0;
      end
   end

   assign o_oor = oor_p1;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         out_p1 <= 1'b0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= i_en;
         if (i_en) begin
            out_p1 <= sel_bit_p0;
         end
      end
   end

   assign o_out   = out_p1;
   assign o_valid = vld_p1;

endmodule

// File: tb/tb_bit_select_mux.sv
// -----------------------------------------------------------------------------
// tb_bit_select_mux
//   Self-checking bench for bit_select_mux. Instances:
//     u_main : WIDTH=32, SEL_WIDTH=5
//     u_w20  : WIDTH=20, SEL_WIDTH=5 (out-of-range indices)
//     u_r0   : WIDTH=2,  SEL_WIDTH=1
//     u_r1   : WIDTH=5,  SEL_WIDTH=3
//     u_r2   : WIDTH=32, SEL_WIDTH=6
//   Honours BIT_MUX_OOR_FLAG_EN for the o_oor port.
// -----------------------------------------------------------------------------
module tb_bit_select_mux;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   logic [31:0] m_data;  logic [4:0] m_sel;  logic m_en;  logic m_out;  logic m_valid;
   logic [19:0] w_data;  logic [4:0] w_sel;  logic w_en;  logic w_out;  logic w_valid;
   logic [1:0]  r0_data; logic       r0_sel; logic r0_en; logic r0_out; logic r0_valid;
   logic [4:0]  r1_data; logic [2:0] r1_sel; logic r1_en; logic r1_out; logic r1_valid;
   logic [31:0] r2_data; logic [5:0] r2_sel; logic r2_en; logic r2_out; logic r2_valid;
`ifdef BIT_MUX_OOR_FLAG_EN
   logic m_oor, w_oor, r0_oor, r1_oor, r2_oor;
`endif

   bit_select_mux #(.WIDTH(32), .SEL_WIDTH(5)) u_main (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(m_data), .i_sel(m_sel), .i_en(m_en),
      .o_out(m_out), .o_valid(m_valid)
`ifdef BIT_MUX_OOR_FLAG_EN
      , .o_oor(m_oor)
`endif
   );

   bit_select_mux #(.WIDTH(20), .SEL_WIDTH(5)) u_w20 (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(w_data), .i_sel(w_sel), .i_en(w_en),
      .o_out(w_out), .o_valid(w_valid)
`ifdef BIT_MUX_OOR_FLAG_EN
      , .o_oor(w_oor)
`endif
   );

   bit_select_mux #(.WIDTH(2), .SEL_WIDTH(1)) u_r0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(r0_data), .i_sel(r0_sel), .i_en(r0_en),
      .o_out(r0_out), .o_valid(r0_valid)
`ifdef BIT_MUX_OOR_FLAG_EN
      , .o_oor(r0_oor)
`endif
   );

   bit_select_mux #(.WIDTH(5), .SEL_WIDTH(3)) u_r1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(r1_data), .i_sel(r1_sel), .i_en(r1_en),
      .o_out(r1_out), .o_valid(r1_valid)
`ifdef BIT_MUX_OOR_FLAG_EN
      , .o_oor(r1_oor)
`endif
   );

   bit_select_mux #(.WIDTH(32), .SEL_WIDTH(6)) u_r2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(r2_data), .i_sel(r2_sel), .i_en(r2_en),
      .o_out(r2_out), .o_valid(r2_valid)
`ifdef BIT_MUX_OOR_FLAG_EN
      , .o_oor(r2_oor)
`endif
   );

   typedef struct {
      logic [31:0] data;
      logic [4:0]  sel;
      logic        en;
      logic        exp_out;
      logic        exp_valid;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Reference selection: bit sel of d when sel < w, else 0.
   function automatic logic model_bit(input logic [31:0] d, input int sel, input int w);
      if (sel < w) return d[sel];
      return 1'b0;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic eo_m, eo_0, eo_1, eo_2;
      logic ev_m, ev_0, ev_1, ev_2;

      // ---- vector table ----
      for (int k = 0; k < 32; k++) begin
         vecs.push_back('{32'd1 << k, 5'(k), 1'b1, 1'b1, 1'b1});
         vecs.push_back('{32'd1 << k, 5'((k + 1) % 32), 1'b1, 1'b0, 1'b1});
      end
      vecs.push_back('{32'h8000_0000, 5'd31, 1'b1, 1'b1, 1'b1});
      vecs.push_back('{32'h0000_0000, 5'd31, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{32'h0000_0000, 5'd0,  1'b0, 1'b1, 1'b0});
      vecs.push_back('{32'h0000_0001, 5'd5,  1'b1, 1'b0, 1'b1});
      vecs.push_back('{32'hFFFF_FFFF, 5'd17, 1'b1, 1'b1, 1'b1});
      vecs.push_back('{32'h0000_0000, 5'd17, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{32'hFFFE_FFFF, 5'd16, 1'b1, 1'b0, 1'b1});

      // ---- reset with enable high ----
      rst_n  = 1'b0;
      m_data = 32'hFFFF_FFFF; m_sel = 5'd0; m_en = 1'b1;
      w_data = '0; w_sel = '0; w_en = 1'b0;
      r0_data = '0; r0_sel = '0; r0_en = 1'b0;
      r1_data = '0; r1_sel = '0; r1_en = 1'b0;
      r2_data = '0; r2_sel = '0; r2_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset out", m_out, 1'b0);
      check("reset valid", m_valid, 1'b0);
`ifdef BIT_MUX_OOR_FLAG_EN
      check("reset oor", m_oor, 1'b0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post-reset out", m_out, 1'b1);
      check("post-reset valid", m_valid, 1'b1);

      // ---- table-driven vectors ----
      foreach (vecs[i]) begin
         @(negedge clk);
         m_data = vecs[i].data;
         m_sel  = vecs[i].sel;
         m_en   = vecs[i].en;
         @(posedge clk); #1;
         check($sformatf("vec%0d out", i), m_out, vecs[i].exp_out);
         check($sformatf("vec%0d valid", i), m_valid, vecs[i].exp_valid);
      end

      // ---- unknowns on unselected channels ----
      @(negedge clk);
      m_data = 'x; m_data[7] = 1'b1; m_sel = 5'd7; m_en = 1'b1;
      @(posedge clk); #1;
      check("xdata sel7 one", m_out, 1'b1);
      @(negedge clk);
      m_data[7] = 1'b0;
      @(posedge clk); #1;
      check("xdata sel7 zero", m_out, 1'b0);

      // ---- out of range on WIDTH=20 ----
      m_en = 1'b0;
      for (int s = 19; s < 32; s++) begin
         @(negedge clk);
         w_data = 20'hF_FFFF; w_sel = 5'(s); w_en = 1'b1;
         @(posedge clk); #1;
         check($sformatf("w20 sel%0d out", s), w_out, (s == 19) ? 1'b1 : 1'b0);
         check($sformatf("w20 sel%0d valid", s), w_valid, 1'b1);
`ifdef BIT_MUX_OOR_FLAG_EN
         check($sformatf("w20 sel%0d oor", s), w_oor, (s >= 20) ? 1'b1 : 1'b0);
`endif
      end
      @(negedge clk);
      w_data = 'x; w_sel = 5'd25;
      @(posedge clk); #1;
      check("w20 xdata sel25 out", w_out, 1'b0);
      @(negedge clk);
      w_data = 20'h0_0001; w_sel = 5'd0;
      @(posedge clk); #1;
      check("w20 sel0 out", w_out, 1'b1);
`ifdef BIT_MUX_OOR_FLAG_EN
      check("w20 sel0 oor", w_oor, 1'b0);
      @(negedge clk);
      w_sel = 5'd30;
      @(posedge clk); #1;
      @(negedge clk);
      w_en = 1'b0; w_sel = 5'd0;
      @(posedge clk); #1;
      check("w20 oor hold", w_oor, 1'b1);
`endif
      w_en = 1'b0;

      // ---- enable hold ----
      @(negedge clk);
      m_data = 32'h0000_0100; m_sel = 5'd8; m_en = 1'b1;
      @(posedge clk); #1;
      check("hold capture out", m_out, 1'b1);
      @(negedge clk);
      m_data = 32'h0; m_en = 1'b0;
      @(posedge clk); #1;
      check("hold out", m_out, 1'b1);
      check("hold valid", m_valid, 1'b0);
      @(posedge clk); #1;
      check("hold out 2", m_out, 1'b1);

      // ---- asynchronous reset between edges ----
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async reset out", m_out, 1'b0);
      check("async reset w20 out", w_out, 1'b0);
      @(negedge clk);
      m_data = 32'hFFFF_FFFF; m_sel = 5'd3; m_en = 1'b1;
      @(posedge clk); #1;
      check("reset held out", m_out, 1'b0);
      check("reset held valid", m_valid, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("reset release out", m_out, 1'b1);
      check("reset release valid", m_valid, 1'b1);

      // ---- random against the reference selection ----
      eo_m = 1'b0; eo_0 = 1'b0; eo_1 = 1'b0; eo_2 = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         m_data  = $urandom;      m_sel  = 5'($urandom);  m_en  = (i == 0) ? 1'b1 : 1'($urandom);
         r0_data = 2'($urandom);  r0_sel = 1'($urandom);  r0_en = (i == 0) ? 1'b1 : 1'($urandom);
         r1_data = 5'($urandom);  r1_sel = 3'($urandom);  r1_en = (i == 0) ? 1'b1 : 1'($urandom);
         r2_data = $urandom;      r2_sel = 6'($urandom);  r2_en = (i == 0) ? 1'b1 : 1'($urandom);
         if (m_en)  eo_m = model_bit(m_data, int'(m_sel), 32);
         if (r0_en) eo_0 = model_bit({30'd0, r0_data}, int'(r0_sel), 2);
         if (r1_en) eo_1 = model_bit({27'd0, r1_data}, int'(r1_sel), 5);
         if (r2_en) eo_2 = model_bit(r2_data, int'(r2_sel), 32);
         ev_m = m_en; ev_0 = r0_en; ev_1 = r1_en; ev_2 = r2_en;
         @(posedge clk); #1;
         check("rand w32s5 out", m_out, eo_m);
         check("rand w32s5 valid", m_valid, ev_m);
         check("rand w2s1 out", r0_out, eo_0);
         check("rand w2s1 valid", r0_valid, ev_0);
         check("rand w5s3 out", r1_out, eo_1);
         check("rand w5s3 valid", r1_valid, ev_1);
         check("rand w32s6 out", r2_out, eo_2);
         check("rand w32s6 valid", r2_valid, ev_2);
`ifdef BIT_MUX_OOR_FLAG_EN
         if (r1_en) check("rand w5s3 oor", r1_oor, (int'(r1_sel) >= 5) ? 1'b1 : 1'b0);
         if (r2_en) check("rand w32s6 oor", r2_oor, (int'(r2_sel) >= 32) ? 1'b1 : 1'b0);
`endif
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
